// File: rtl/write_iq.sv
`timescale 1ns/1ps
// write_iq: pops one I and one Q quantized sample, dequantizes and saturates
// each to CHAR_SIZE bits, and emits four little-endian bytes (I lo, I hi,
// Q lo, Q hi) into a byte FIFO.
// Latency: pop in READ, first byte the next cycle; minimum 5 cycles per pair.
// Backpressure: empty sample FIFOs stall READ only; out_full holds B0..B3
// with data_out stable.
// Ports:
//   clock, reset          - rising-edge clock, async active-high reset
//   i_empty/q_empty       - sample FIFO empty flags (FWFT data on i_in/q_in)
//   i_rd_en/q_rd_en       - pop strobes, always asserted together
//   out_full              - byte FIFO full
//   out_wr_en/data_out    - byte FIFO push strobe and byte
module write_iq #(
  parameter int DATA_SIZE = 32,
  parameter int CHAR_SIZE = 16,
  parameter int BYTE      = 8,
  parameter int BITS      = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_empty,
  input  logic                 q_empty,
  output logic                 i_rd_en,
  output logic                 q_rd_en,
  input  logic [DATA_SIZE-1:0] i_in,
  input  logic [DATA_SIZE-1:0] q_in,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [BYTE-1:0]      data_out
);

  typedef enum logic [2:0] {READ, B0, B1, B2, B3} state_t;

  // Rounding bias turns the arithmetic shift (floor) into truncation toward
  // zero for negative inputs.
  localparam logic signed [DATA_SIZE-1:0] BIAS    = DATA_SIZE'((64'sd1 <<< BITS) - 64'sd1);
  localparam logic signed [DATA_SIZE-1:0] SAT_MAX = DATA_SIZE'((64'sd1 <<< (CHAR_SIZE-1)) - 64'sd1);
  localparam logic signed [DATA_SIZE-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [CHAR_SIZE-1:0] deq(input logic signed [DATA_SIZE-1:0] x);
    logic signed [DATA_SIZE-1:0] t;
    if (x[DATA_SIZE-1]) t = (x + BIAS) >>> BITS;
    else                t = x >>> BITS;
    if (t > SAT_MAX)      t = SAT_MAX;
    else if (t < SAT_MIN) t = SAT_MIN;
    return CHAR_SIZE'(t);
  endfunction

  state_t                      state, state_nxt;
  logic signed [CHAR_SIZE-1:0] i_reg, q_reg;
  logic                        pop, push;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= READ;
      i_reg <= '0;
      q_reg <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        i_reg <= deq(i_in);
        q_reg <= deq(q_in);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    push      = 1'b0;
    data_out  = '0;
    case (state)
      READ: begin
        // Both FIFOs must have data; a lone pop would misalign I and Q.
        if (!i_empty && !q_empty) begin
          pop       = 1'b1;
          state_nxt = B0;
        end
      end
      B0: begin
        data_out = i_reg[BYTE-1:0];
        if (!out_full) begin
          push      = 1'b1;
          state_nxt = B1;
        end
      end
      B1: begin
        data_out = i_reg[2*BYTE-1:BYTE];
        if (!out_full) begin
          push      = 1'b1;
          state_nxt = B2;
        end
      end
      B2: begin
        data_out = q_reg[BYTE-1:0];
        if (!out_full) begin
          push      = 1'b1;
          state_nxt = B3;
        end
      end
      B3: begin
        data_out = q_reg[2*BYTE-1:BYTE];
        if (!out_full) begin
          push      = 1'b1;
          state_nxt = READ;
        end
      end
      default: state_nxt = READ;
    endcase
  end

  // Strobes are masked by reset so nothing pops or pushes while it is held,
  // even though READ would otherwise see non-empty FIFOs.
  assign i_rd_en   = pop & ~reset;
  assign q_rd_en   = pop & ~reset;
  assign out_wr_en = push & ~reset;

endmodule

// File: tb/tb_write_iq.sv
`timescale 1ns/1ps
module tb_write_iq;
  localparam int DATA_SIZE = 32;
  localparam int CHAR_SIZE = 16;
  localparam int BYTE      = 8;
  localparam int BITS      = 10;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 i_empty = 1'b0;
  logic                 q_empty = 1'b0;
  logic                 out_full = 1'b0;
  logic [DATA_SIZE-1:0] i_in = '0;
  logic [DATA_SIZE-1:0] q_in = '0;
  logic                 i_rd_en, q_rd_en, out_wr_en;
  logic [BYTE-1:0]      data_out;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got[$];
  int         mark;

  always #5 clock = ~clock;

  write_iq #(.DATA_SIZE(DATA_SIZE), .CHAR_SIZE(CHAR_SIZE), .BYTE(BYTE), .BITS(BITS)) dut (
    .clock(clock), .reset(reset),
    .i_empty(i_empty), .q_empty(q_empty),
    .i_rd_en(i_rd_en), .q_rd_en(q_rd_en),
    .i_in(i_in), .q_in(q_in),
    .out_full(out_full), .out_wr_en(out_wr_en), .data_out(data_out)
  );

  // Byte FIFO model: whatever is presented with out_wr_en is taken at the edge.
  always @(negedge clock) if (out_wr_en === 1'b1) got.push_back(data_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  // One full pair with no backpressure; b = {I lo, I hi, Q lo, Q hi}.
  task automatic pair(input string tag, input logic [31:0] i, input logic [31:0] q,
                      input logic [31:0] b);
    cyc;
    i_in = i; q_in = q; i_empty = 1'b0; q_empty = 1'b0;
    #1;
    chk({tag, " i_pop"}, i_rd_en, 32'h1);
    chk({tag, " q_pop"}, q_rd_en, 32'h1);
    chk({tag, " no_wr_in_read"}, out_wr_en, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc;
      i_empty = 1'b1; q_empty = 1'b1;
      #1;
      chk($sformatf("%s wr%0d", tag, k), out_wr_en, 32'h1);
      chk($sformatf("%s byte%0d", tag, k), data_out, b[31-8*k -: 8]);
      chk($sformatf("%s no_pop%0d", tag, k), i_rd_en, 32'h0);
    end
    cyc;
    #1;
    chk({tag, " back_read_wr"}, out_wr_en, 32'h0);
    chk({tag, " back_read_dat"}, data_out, 32'h0);
  endtask

  initial begin
    // Reset with non-empty FIFOs: no strobe may fire.
    #2;
    chk("rst i_rd_en", i_rd_en, 32'h0);
    chk("rst q_rd_en", q_rd_en, 32'h0);
    chk("rst out_wr_en", out_wr_en, 32'h0);
    chk("rst data_out", data_out, 32'h0);
    cyc;
    i_empty = 1'b1; q_empty = 1'b1;
    reset = 1'b0;

    pair("basic", 32'd1024000, -32'sd1024000, 32'hE8_03_18_FC);
    pair("trunc", -32'sd1, 32'd1023, 32'h00_00_00_00);
    pair("sat", 32'd40960000, -32'sd40960000, 32'hFF_7F_00_80);

    // Only I available: READ must not pop either FIFO.
    for (int k = 0; k < 10; k++) begin
      cyc;
      i_empty = 1'b0; q_empty = 1'b1;
      #1;
      chk($sformatf("q_empty i_rd%0d", k), i_rd_en, 32'h0);
      chk($sformatf("q_empty q_rd%0d", k), q_rd_en, 32'h0);
      chk($sformatf("q_empty wr%0d", k), out_wr_en, 32'h0);
    end
    pair("after_empty", 32'd3072, -32'sd3072, 32'h03_00_FD_FF);

    // Backpressure in B2.
    mark = got.size();
    cyc;
    i_in = 32'h1234 << 10; q_in = 32'h5678 << 10; i_empty = 1'b0; q_empty = 1'b0;
    #1;
    chk("full pop", i_rd_en, 32'h1);
    cyc; i_empty = 1'b1; q_empty = 1'b1; #1;
    chk("full b0 dat", data_out, 32'h34);
    cyc; #1;
    chk("full b1 dat", data_out, 32'h12);
    for (int k = 0; k < 3; k++) begin
      cyc;
      out_full = 1'b1;
      #1;
      chk($sformatf("full hold wr%0d", k), out_wr_en, 32'h0);
      chk($sformatf("full hold dat%0d", k), data_out, 32'h78);
    end
    cyc; out_full = 1'b0; #1;
    chk("full b2 wr", out_wr_en, 32'h1);
    chk("full b2 dat", data_out, 32'h78);
    cyc; #1;
    chk("full b3 dat", data_out, 32'h56);
    cyc; #1;
    chk("full back_read", out_wr_en, 32'h0);
    chk("full count", got.size() - mark, 32'd4);
    if (got.size() >= mark + 4) begin
      chk("full q0", got[mark],   32'h34);
      chk("full q1", got[mark+1], 32'h12);
      chk("full q2", got[mark+2], 32'h78);
      chk("full q3", got[mark+3], 32'h56);
    end

    // Asynchronous reset in B2.
    cyc;
    i_in = 32'd175104; q_in = 32'd209920; i_empty = 1'b0; q_empty = 1'b0;
    #1;
    chk("mid pop", q_rd_en, 32'h1);
    cyc; i_empty = 1'b1; q_empty = 1'b1; #1;
    chk("mid b0", data_out, 32'hAB);
    cyc; #1;
    chk("mid b1", data_out, 32'h00);
    cyc; #1;
    chk("mid b2 wr", out_wr_en, 32'h1);
    chk("mid b2 dat", data_out, 32'hCD);
    mark = got.size();
    #1 reset = 1'b1;
    #1;
    chk("mid rst wr", out_wr_en, 32'h0);
    chk("mid rst dat", data_out, 32'h0);
    cyc; cyc;
    chk("mid rst no_bytes", got.size(), mark);
    reset = 1'b0;
    pair("post_rst", -32'sd2048, 32'd5000, 32'hFE_FF_04_00);

    chk("total bytes", got.size(), 32'd26);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
